// File: rtl/pulse_cmd_regbank.sv
// pulse_cmd_regbank: framed UART command receiver feeding a bank of
// pulse-timing registers.
//
// A frame is PAYLOAD_BYTES payload bytes (LSB first) followed by one
// control byte: [6:0] = register address, [7] = read flag (reserved when
// readback is not built in). Every accepted frame writes one register and
// answers with a checksum byte: the payload sum mod 256, inverted when the
// address is rejected. Partial frames that stall longer than TIMEOUT_CYC
// idle cycles are dropped. Bytes arriving while the block is busy are
// dropped. Timeouts, dropped bytes and rejected addresses all count in a
// saturating error counter.
//
// Optional build macro: PULSE_REGBANK_READBACK_EN
//   When defined, a control byte with bit 7 set and a valid address is a
//   read. The block writes nothing and returns the register, zero-extended
//   to PAYLOAD_BYTES bytes, LSB first. Each byte uses its own
//   tx_start/tx_busy handshake.
module pulse_cmd_regbank #(
  parameter int DATA_W        = 32,
  parameter int PAYLOAD_BYTES = 4,
  parameter int NUM_REGS      = 8,
  parameter int TIMEOUT_CYC   = 2000000,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = {NUM_REGS*DATA_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_byte,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        upd_stb,
  output logic                       frame_done,
  output logic [7:0]                 err_cnt,
  output logic                       busy
);

`ifdef PULSE_REGBANK_READBACK_EN
  localparam bit READBACK_EN = 1'b1;
`else
  localparam bit READBACK_EN = 1'b0;
`endif

  localparam int PW    = 8 * PAYLOAD_BYTES;
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] RD_LAST  = IDX_W'(PAYLOAD_BYTES - 1);
  // Counter value on which the next idle cycle expires the frame.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  typedef enum logic [1:0] {
    ST_RECV    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_TX_REQ  = 2'd2,
    ST_TX_WAIT = 2'd3
  } state_e;

  state_e                       state_q;
  logic [CNT_W-1:0]             byte_cnt_q;
  logic [7:0]                   csum_q;
  logic [PW-1:0]                payload_q;
  logic [7:0]                   ctrl_q;
  logic [TMO_W-1:0]             tmo_q;
  logic [NUM_REGS*DATA_W-1:0]   regs_q;
  logic [NUM_REGS-1:0]          upd_stb_q;
  logic                         tx_start_q;
  logic [7:0]                   tx_byte_q;
  logic                         frame_done_q;
  logic [7:0]                   err_cnt_q;
  logic [7:0]                   err_cnt_d;
  logic                         busy_q;
  logic                         wait_skip_q;
  logic                         rd_mode_q;
  logic [IDX_W-1:0]             rd_idx_q;
  logic [PW-1:0]                rd_shift_q;

  logic [6:0]                   addr_s;
  logic                         addr_ok_s;
  logic                         wr_ok_s;
  logic                         rd_ok_s;
  logic                         tmo_hit_s;
  logic                         overrun_s;
  logic                         inval_s;
  logic                         err_evt_s;
  logic [DATA_W-1:0]            reg_rd_s;
  logic [PW-1:0]                rd_ext_s;

  // Address decode of the latched control byte.
  assign addr_s    = ctrl_q[6:0];
  assign addr_ok_s = ({25'd0, addr_s} < 32'(NUM_REGS));
  assign wr_ok_s   = addr_ok_s & ~ctrl_q[7];
  assign rd_ok_s   = READBACK_EN & addr_ok_s & ctrl_q[7];

  // Error sources. A byte arriving outside RECV is an overrun. A rejected
  // control byte counts only in EXEC.
  assign overrun_s = rx_valid & (state_q != ST_RECV);
  assign inval_s   = (state_q == ST_EXEC) & ~wr_ok_s & ~rd_ok_s;
  assign err_evt_s = overrun_s | tmo_hit_s | inval_s;

  // Read mux used by the readback response.
  always_comb begin
    reg_rd_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_s == 7'(i)) begin
        reg_rd_s = regs_q[i*DATA_W +: DATA_W];
      end else begin
        reg_rd_s = reg_rd_s;
      end
    end
  end

  assign rd_ext_s = PW'(reg_rd_s);

  // Expiry of a stalled partial frame (never fires when TIMEOUT_CYC is 0).
  always_comb begin
    tmo_hit_s = 1'b0;
    if ((TIMEOUT_CYC != 0) && (state_q == ST_RECV) && !rx_valid &&
        (byte_cnt_q != {CNT_W{1'b0}}) && (tmo_q == TMO_LAST)) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Saturating error count; simultaneous events add one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Idle-cycle counter; runs only while a partial frame is pending in RECV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= {TMO_W{1'b0}};
    end else if ((state_q != ST_RECV) || rx_valid ||
                 (byte_cnt_q == {CNT_W{1'b0}}) || tmo_hit_s) begin
      tmo_q <= {TMO_W{1'b0}};
    end else if (TIMEOUT_CYC != 0) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  // Register bank: one write per accepted frame, with its update strobe
  // rising on the same edge as the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= RESET_VAL;
      upd_stb_q <= {NUM_REGS{1'b0}};
    end else begin
      upd_stb_q <= {NUM_REGS{1'b0}};
      if ((state_q == ST_EXEC) && wr_ok_s) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_s == 7'(i)) begin
            regs_q[i*DATA_W +: DATA_W] <= payload_q[DATA_W-1:0];
            upd_stb_q[i]               <= 1'b1;
          end
        end
      end
    end
  end

  // Frame sequencer: byte collection, response byte selection and the
  // transmitter handshake. tx_start and frame_done are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RECV;
      byte_cnt_q   <= {CNT_W{1'b0}};
      csum_q       <= 8'd0;
      payload_q    <= {PW{1'b0}};
      ctrl_q       <= 8'd0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= 8'd0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      wait_skip_q  <= 1'b0;
      rd_mode_q    <= 1'b0;
      rd_idx_q     <= {IDX_W{1'b0}};
      rd_shift_q   <= {PW{1'b0}};
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_RECV: begin
          if (rx_valid) begin
            if (byte_cnt_q == CNT_FULL) begin
              ctrl_q  <= rx_byte;
              state_q <= ST_EXEC;
              busy_q  <= 1'b1;
            end else begin
              for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                if (byte_cnt_q == CNT_W'(i)) begin
                  payload_q[8*i +: 8] <= rx_byte;
                end
              end
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
              csum_q     <= csum_q + rx_byte;
            end
          end else if (tmo_hit_s) begin
            byte_cnt_q <= {CNT_W{1'b0}};
            csum_q     <= 8'd0;
          end
        end
        ST_EXEC: begin
          byte_cnt_q <= {CNT_W{1'b0}};
          csum_q     <= 8'd0;
          rd_idx_q   <= {IDX_W{1'b0}};
          state_q    <= ST_TX_REQ;
          if (rd_ok_s) begin
            rd_mode_q  <= 1'b1;
            tx_byte_q  <= rd_ext_s[7:0];
            rd_shift_q <= rd_ext_s >> 8;
          end else if (wr_ok_s) begin
            rd_mode_q <= 1'b0;
            tx_byte_q <= csum_q;
          end else begin
            rd_mode_q <= 1'b0;
            tx_byte_q <= ~csum_q;
          end
        end
        ST_TX_REQ: begin
          if (!tx_busy) begin
            tx_start_q  <= 1'b1;
            wait_skip_q <= 1'b1;
            state_q     <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          // The transmitter may raise busy a cycle late, so the first cycle
          // after tx_start does not look at tx_busy.
          if (wait_skip_q) begin
            wait_skip_q <= 1'b0;
          end else if (!tx_busy) begin
            if (rd_mode_q && (rd_idx_q != RD_LAST)) begin
              rd_idx_q   <= rd_idx_q + IDX_W'(1);
              tx_byte_q  <= rd_shift_q[7:0];
              rd_shift_q <= rd_shift_q >> 8;
              state_q    <= ST_TX_REQ;
            end else begin
              frame_done_q <= 1'b1;
              rd_mode_q    <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= ST_RECV;
            end
          end
        end
        default: begin
          state_q <= ST_RECV;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign regs_flat  = regs_q;
  assign upd_stb    = upd_stb_q;
  assign frame_done = frame_done_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_cmd_regbank.sv
// Directed bench for pulse_cmd_regbank (8 x 32-bit registers, 4-byte payload,
// short timeout). It exercises both the default build and the
// PULSE_REGBANK_READBACK_EN build.
`timescale 1ns/1ps
module tb_pulse_cmd_regbank;
  localparam int DATA_W = 32;
  localparam int PB     = 4;
  localparam int NR     = 8;
  localparam int TMO    = 40;
  localparam logic [NR*DATA_W-1:0] RV = {
    32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
    32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'd0;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic [NR*DATA_W-1:0] regs_flat;
  logic [NR-1:0]     upd_stb;
  logic              frame_done;
  logic [7:0]        err_cnt;
  logic              busy;

  pulse_cmd_regbank #(
    .DATA_W(DATA_W), .PAYLOAD_BYTES(PB), .NUM_REGS(NR),
    .TIMEOUT_CYC(TMO), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .regs_flat(regs_flat), .upd_stb(upd_stb), .frame_done(frame_done),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model and output monitor, sampled on the falling edge.
  int          n_vec = 0;
  int          n_miss = 0;
  int          n_start = 0;
  int          n_done = 0;
  int          n_upd = 0;
  int          upd_cyc = 0;
  int          rxv_cyc = 0;
  int          tx_busy_cnt = 0;
  int          glitch = 0;
  int          exp_err = 0;
  bit          start_prev = 1'b0;
  logic        force_busy = 1'b0;
  logic [NR-1:0]        upd_val = '0;
  logic [NR*DATA_W-1:0] upd_regs = '0;
  logic [7:0]  tx_q[$];
  logic [31:0] model[NR];

  assign tx_busy = force_busy | (tx_busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      tx_q.push_back(tx_byte);
      n_start = n_start + 1;
      tx_busy_cnt = 3;
      if (start_prev) glitch = glitch + 1;
    end else if (tx_busy_cnt > 0) begin
      tx_busy_cnt = tx_busy_cnt - 1;
    end
    start_prev = tx_start;
    if (frame_done) n_done = n_done + 1;
    if (upd_stb != '0) begin
      n_upd    = n_upd + 1;
      upd_val  = upd_stb;
      upd_cyc  = cyc;
      upd_regs = regs_flat;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_reg%0d", tag, i), 64'(regs_flat[i*DATA_W +: DATA_W]), 64'(model[i]));
  endtask

  task automatic clear_mon();
    n_start = 0; n_done = 0; n_upd = 0; upd_val = '0;
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    rxv_cyc  = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] c);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(c);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    idle(2);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NR; i++) model[i] = 32'hA5A5_0000 + 32'(i);
  endtask

  initial begin
    reset_model();
    // Reset state while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_upd", 64'(upd_stb), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check_regs("rst");
    rst_n = 1'b1;
    idle(10);
    check("idle_start", 64'(n_start), 64'd0);
    check("idle_err", 64'(err_cnt), 64'd0);
    check_regs("idle");

    // Valid write to reg1: checksum 0x10+0x27 = 0x37.
    clear_mon();
    send_frame(8'h10, 8'h27, 8'h00, 8'h00, 8'h01);
    check("w1_busy", 64'(busy), 64'd1);
    wait_done(50);
    model[1] = 32'h0000_2710;
    check("w1_upd_val", 64'(upd_val), 64'h02);
    check("w1_upd_n", 64'(n_upd), 64'd1);
    check("w1_upd_lat", 64'(upd_cyc - rxv_cyc), 64'd2);
    check("w1_upd_same", 64'(upd_regs[1*DATA_W +: DATA_W]), 64'h2710);
    check("w1_start_n", 64'(n_start), 64'd1);
    check("w1_txq_n", 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) check("w1_tx", 64'(tx_q[0]), 64'h37);
    check("w1_done", 64'(n_done), 64'd1);
    check("w1_err", 64'(err_cnt), 64'd0);
    check("w1_busy_end", 64'(busy), 64'd0);
    check_regs("w1");

    // Out-of-range address 9: response is ~0x0A.
    clear_mon();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h09);
    wait_done(50);
    exp_err = exp_err + 1;
    check("bad_upd_n", 64'(n_upd), 64'd0);
    if (tx_q.size() > 0) check("bad_tx", 64'(tx_q[0]), 64'hF5);
    check("bad_start_n", 64'(n_start), 64'd1);
    check("bad_err", 64'(err_cnt), 64'(exp_err));
    check_regs("bad");

`ifndef PULSE_REGBANK_READBACK_EN
    // Bit 7 set is rejected without readback: sum 4, response 0xFB.
    clear_mon();
    send_frame(8'h01, 8'h01, 8'h01, 8'h01, 8'h81);
    wait_done(50);
    exp_err = exp_err + 1;
    check("b7_upd_n", 64'(n_upd), 64'd0);
    if (tx_q.size() > 0) check("b7_tx", 64'(tx_q[0]), 64'hFB);
    check("b7_err", 64'(err_cnt), 64'(exp_err));
    check_regs("b7");
`endif

    // Rejected address and an overrun on the same edge add only one.
    clear_mon();
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h0A);
    send_byte(8'h55);
    wait_done(50);
    exp_err = exp_err + 1;
    if (tx_q.size() > 0) check("dbl_tx", 64'(tx_q[0]), 64'hFF);
    check("dbl_err", 64'(err_cnt), 64'(exp_err));

    // Partial frame expires after TMO idle cycles; the next frame lands in reg0.
    clear_mon();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(TMO);
    exp_err = exp_err + 1;
    check("tmo_err", 64'(err_cnt), 64'(exp_err));
    check("tmo_start", 64'(n_start), 64'd0);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
    wait_done(50);
    model[0] = 32'h4433_2211;
    check("tmo_start_n", 64'(n_start), 64'd1);
    if (tx_q.size() > 0) check("tmo_tx", 64'(tx_q[0]), 64'hAA);
    check("tmo_err2", 64'(err_cnt), 64'(exp_err));
    check_regs("tmo");

    // Gaps of TMO-1 idle cycles between bytes are still one frame.
    clear_mon();
    send_byte(8'h01); idle(TMO - 1);
    send_byte(8'h02); idle(TMO - 1);
    send_byte(8'h03); idle(TMO - 1);
    send_byte(8'h04); idle(TMO - 1);
    send_byte(8'h03);
    wait_done(50);
    model[3] = 32'h0403_0201;
    check("gap_err", 64'(err_cnt), 64'(exp_err));
    check("gap_upd", 64'(upd_val), 64'h08);
    if (tx_q.size() > 0) check("gap_tx", 64'(tx_q[0]), 64'h0A);
    check_regs("gap");

    // Transmitter busy for 100 cycles: no tx_start until it drops; an
    // overrun during the wait is counted and dropped.
    clear_mon();
    force_busy = 1'b1;
    send_frame(8'h78, 8'h56, 8'h34, 8'h12, 8'h02);
    idle(50);
    check("hold_start0", 64'(n_start), 64'd0);
    send_byte(8'h99);
    exp_err = exp_err + 1;
    idle(49);
    check("hold_start1", 64'(n_start), 64'd0);
    check("hold_err", 64'(err_cnt), 64'(exp_err));
    force_busy = 1'b0;
    wait_done(50);
    model[2] = 32'h1234_5678;
    check("hold_start_n", 64'(n_start), 64'd1);
    if (tx_q.size() > 0) check("hold_tx", 64'(tx_q[0]), 64'h14);
    check_regs("hold");
    clear_mon();
    send_frame(8'h01, 8'h00, 8'h00, 8'h80, 8'h04);
    wait_done(50);
    model[4] = 32'h8000_0001;
    if (tx_q.size() > 0) check("post_tx", 64'(tx_q[0]), 64'h81);
    check_regs("post");

`ifdef PULSE_REGBANK_READBACK_EN
    // Readback of reg2: four bytes LSB first, nothing written.
    clear_mon();
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h82);
    wait_done(100);
    check("rb_start_n", 64'(n_start), 64'd4);
    check("rb_done", 64'(n_done), 64'd1);
    check("rb_upd_n", 64'(n_upd), 64'd0);
    if (tx_q.size() == 4) begin
      check("rb_b0", 64'(tx_q[0]), 64'h78);
      check("rb_b1", 64'(tx_q[1]), 64'h56);
      check("rb_b2", 64'(tx_q[2]), 64'h34);
      check("rb_b3", 64'(tx_q[3]), 64'h12);
    end
    check("rb_err", 64'(err_cnt), 64'(exp_err));
    check_regs("rb");
`endif

    // Error counter saturates at 255 under a long overrun burst.
    clear_mon();
    force_busy = 1'b1;
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h05);
    rx_byte  = 8'h3C;
    rx_valid = 1'b1;
    idle(300);
    rx_valid = 1'b0;
    check("sat_err", 64'(err_cnt), 64'd255);
    force_busy = 1'b0;
    wait_done(50);
    model[5] = 32'h0;
    check("sat_err2", 64'(err_cnt), 64'd255);
    check_regs("sat");

    // Reset mid-frame restores reset values; a fresh frame then starts clean.
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst_n = 1'b0;
    #1;
    reset_model();
    check("mrst_err", 64'(err_cnt), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_tx_byte", 64'(tx_byte), 64'd0);
    check_regs("mrst");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_mon();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h06);
    wait_done(50);
    model[6] = 32'h0403_0201;
    if (tx_q.size() > 0) check("after_tx", 64'(tx_q[0]), 64'h0A);
    check("after_err", 64'(err_cnt), 64'd0);
    check_regs("after");

    check("start_width", 64'(glitch), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
